// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder and the control decoder:
// mnemonic codes, primary opcodes, R-type funct codes, REGIMM rt selectors.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        MN_NOP   = 5'd0,
        MN_ADD   = 5'd1,
        MN_ADDU  = 5'd2,
        MN_SUB   = 5'd3,
        MN_SUBU  = 5'd4,
        MN_AND   = 5'd5,
        MN_OR    = 5'd6,
        MN_XOR   = 5'd7,
        MN_NOR   = 5'd8,
        MN_SLT   = 5'd9,
        MN_SLL   = 5'd10,
        MN_SRL   = 5'd11,
        MN_JR    = 5'd12,
        MN_JALR  = 5'd13,
        MN_ADDI  = 5'd14,
        MN_ADDIU = 5'd15,
        MN_SLTI  = 5'd16,
        MN_ANDI  = 5'd17,
        MN_ORI   = 5'd18,
        MN_XORI  = 5'd19,
        MN_LW    = 5'd20,
        MN_SW    = 5'd21,
        MN_BEQ   = 5'd22,
        MN_BNE   = 5'd23,
        MN_BLTZ  = 5'd24,
        MN_BGEZ  = 5'd25,
        MN_J     = 5'd26,
        MN_JAL   = 5'd27
    } mnem_e;

    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_REGIMM = 6'd1;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_ADDI   = 6'd8;
    localparam logic [5:0] OP_ADDIU  = 6'd9;
    localparam logic [5:0] OP_SLTI   = 6'd10;
    localparam logic [5:0] OP_ANDI   = 6'd12;
    localparam logic [5:0] OP_ORI    = 6'd13;
    localparam logic [5:0] OP_XORI   = 6'd14;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    function automatic logic [31:0] pack_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                           logic [4:0] sh, logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] pack_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                           logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational mnemonic + fields -> 32-bit MIPS word, with an illegal-mnemonic flag.
// Unused fields are forced to zero so every word decodes back to exactly one operation.
module instr_field_packer
    import mips_isa_pkg::*;
(
    input  logic [4:0]  mnem_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [25:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = 32'h0;
        illegal_o = 1'b0;
        case (mnem_i)
            MN_NOP:   word_o = 32'h0;
            MN_ADD:   word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
            MN_ADDU:  word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FN_ADDU);
            MN_SUB:   word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
            MN_SUBU:  word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FN_SUBU);
            MN_AND:   word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FN_AND);
            MN_OR:    word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FN_OR);
            MN_XOR:   word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
            MN_NOR:   word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FN_NOR);
            MN_SLT:   word_o = pack_r(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
            MN_SLL:   word_o = pack_r(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
            MN_SRL:   word_o = pack_r(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
            MN_JR:    word_o = pack_r(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_JALR:  word_o = pack_r(rs_i, 5'd0, rd_i, 5'd0, FN_JALR);
            MN_ADDI:  word_o = pack_i(OP_ADDI,  rs_i, rt_i, imm_i[15:0]);
            MN_ADDIU: word_o = pack_i(OP_ADDIU, rs_i, rt_i, imm_i[15:0]);
            MN_SLTI:  word_o = pack_i(OP_SLTI,  rs_i, rt_i, imm_i[15:0]);
            MN_ANDI:  word_o = pack_i(OP_ANDI,  rs_i, rt_i, imm_i[15:0]);
            MN_ORI:   word_o = pack_i(OP_ORI,   rs_i, rt_i, imm_i[15:0]);
            MN_XORI:  word_o = pack_i(OP_XORI,  rs_i, rt_i, imm_i[15:0]);
            MN_LW:    word_o = pack_i(OP_LW,    rs_i, rt_i, imm_i[15:0]);
            MN_SW:    word_o = pack_i(OP_SW,    rs_i, rt_i, imm_i[15:0]);
            MN_BEQ:   word_o = pack_i(OP_BEQ,   rs_i, rt_i, imm_i[15:0]);
            MN_BNE:   word_o = pack_i(OP_BNE,   rs_i, rt_i, imm_i[15:0]);
            // REGIMM branches select the condition through the rt field
            MN_BLTZ:  word_o = pack_i(OP_REGIMM, rs_i, RT_BLTZ, imm_i[15:0]);
            MN_BGEZ:  word_o = pack_i(OP_REGIMM, rs_i, RT_BGEZ, imm_i[15:0]);
            MN_J:     word_o = {OP_J, imm_i};
            MN_JAL:   word_o = {OP_JAL, imm_i};
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts symbolic instructions, writes encoded words to consecutive
// addresses from 0; one word per cycle, write strobe one cycle after accept.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0] enc_word;
    logic        enc_illegal;

    instr_field_packer u_packer (
        .mnem_i    (in_mnem),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .shamt_i   (in_shamt),
        .imm_i     (in_imm),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid && ready_q) begin
                    if (enc_illegal) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        cnt_d   = cnt_q + (ADDR_W+1)'(1);
                        // last address terminates the session instead of wrapping
                        if (ptr_q == {ADDR_W{1'b1}} || in_last) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                        if (ptr_q != {ADDR_W{1'b1}}) begin
                            ptr_d = ptr_q + ADDR_W'(1);
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
        endcase
        ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = cnt_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed + randomized bench for mips_instr_encoder against a table-driven encoding model.
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, in_valid, in_last;
    logic [4:0]  in_mnem, in_rs, in_rt, in_rd, in_shamt;
    logic [25:0] in_imm;
    logic        in_ready, imem_we, done, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  word_count;

    logic        start_b, valid_b;
    logic        ready_b, we_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  wc_b;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ptr = 0;
    int exp_cnt = 0;

    int r_funct [13] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 0, 2, 8, 9};
    int i_op    [10] = '{8, 9, 10, 12, 13, 14, 35, 43, 4, 5};

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .word_count(word_count), .done(done), .err(err)
    );

    mips_instr_encoder #(.ADDR_W(2)) dut_small (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_last(in_last), .imem_we(we_b), .imem_addr(addr_b),
        .imem_wdata(wdata_b), .word_count(wc_b), .done(done_b), .err(err_b)
    );

    // bit 32 set means the mnemonic is illegal
    function automatic logic [32:0] ref_enc(int mn, int rs, int rt, int rd, int sh, logic [25:0] imm);
        longint w;
        longint imm16;
        imm16 = longint'(imm) % 65536;
        if (mn >= 28) return {1'b1, 32'h0};
        if (mn == 0) return 33'h0;
        if (mn <= 13) begin
            if (mn == 10 || mn == 11) rs = 0;
            else sh = 0;
            if (mn == 12 || mn == 13) rt = 0;
            if (mn == 12) rd = 0;
            w = rs * 2**21 + rt * 2**16 + rd * 2**11 + sh * 2**6 + r_funct[mn-1];
        end else if (mn <= 23) begin
            w = longint'(i_op[mn-14]) * 2**26 + rs * 2**21 + rt * 2**16 + imm16;
        end else if (mn <= 25) begin
            w = 2**26 + rs * 2**21 + (mn - 24) * 2**16 + imm16;
        end else begin
            w = longint'(mn - 24) * 2**26 + longint'(imm);
        end
        return {1'b0, w[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_ptr = 0;
        exp_cnt = 0;
        chk("start_ready", in_ready, 1);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", err, 0);
        chk("start_count_clr", word_count, 0);
    endtask

    task automatic issue(input int mn, input int rs, input int rt, input int rd, input int sh,
                         input logic [25:0] imm, input bit last, input logic [32:0] expw);
        in_mnem  = mn[4:0];
        in_rs    = rs[4:0];
        in_rt    = rt[4:0];
        in_rd    = rd[4:0];
        in_shamt = sh[4:0];
        in_imm   = imm;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        if (expw[32]) begin
            chk("illegal_no_write", imem_we, 0);
            chk("illegal_err", err, 1);
            chk("illegal_ready", in_ready, 0);
        end else begin
            chk("we", imem_we, 1);
            chk("addr", imem_addr, exp_ptr);
            chk("wdata", imem_wdata, expw[31:0]);
            exp_ptr++;
            exp_cnt++;
            if (last) begin
                chk("last_done", done, 1);
                chk("last_ready_drop", in_ready, 0);
            end
        end
        chk("word_count", word_count, exp_cnt);
    endtask

    initial begin
        int mn, rs, rt, rd, sh;
        logic [25:0] imm;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        start_b = 1'b0; valid_b = 1'b0;
        in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
        #3;
        chk("rst_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", word_count, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 chk("idle_ready", in_ready, 0);

        // basic program: ADD, SW, ADDI with in_last
        pulse_start();
        issue(1, 1, 2, 3, 0, 26'h0, 1'b0, 33'h0_0022_1820);
        issue(21, 29, 5, 0, 0, 26'h8, 1'b0, 33'h0_AFA5_0008);
        issue(14, 0, 8, 0, 0, 26'h3FF_FFFF, 1'b1, 33'h0_2008_FFFF);
        repeat (2) @(posedge clk);
        #1 chk("done_held", done, 1);
        chk("done_count_held", word_count, 3);
        chk("done_no_write", imem_we, 0);

        // field forcing
        pulse_start();
        issue(10, 9, 3, 2, 4, 26'h0, 1'b0, 33'h0_0003_1100);
        issue(25, 4, 0, 0, 0, 26'h3, 1'b0, 33'h0_0481_0003);
        issue(24, 4, 7, 0, 0, 26'h3, 1'b0, 33'h0_0480_0003);
        issue(27, 0, 0, 0, 0, 26'h10, 1'b0, 33'h0_0C00_0010);
        issue(0, 5, 6, 7, 8, 26'h1234, 1'b0, 33'h0_0000_0000);
        issue(12, 31, 5, 0, 0, 26'h0, 1'b1, 33'h0_03E0_0008);

        // illegal mnemonic after two legal words
        pulse_start();
        issue(1, 1, 2, 3, 0, 26'h0, 1'b0, ref_enc(1, 1, 2, 3, 0, 26'h0));
        issue(6, 4, 5, 6, 0, 26'h0, 1'b0, ref_enc(6, 4, 5, 6, 0, 26'h0));
        issue(30, 1, 1, 1, 0, 26'h0, 1'b0, {1'b1, 32'h0});
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("err_ready_held", in_ready, 0);
        chk("err_held", err, 1);
        chk("err_no_write", imem_we, 0);
        chk("err_count_held", word_count, 2);
        pulse_start();

        // randomized program against the model
        for (int i = 0; i < 40; i++) begin
            mn  = int'($urandom_range(0, 27));
            rs  = int'($urandom_range(0, 31));
            rt  = int'($urandom_range(0, 31));
            rd  = int'($urandom_range(0, 31));
            sh  = int'($urandom_range(0, 31));
            imm = 26'($urandom);
            issue(mn, rs, rt, rd, sh, imm, (i == 39), ref_enc(mn, rs, rt, rd, sh, imm));
        end
        // random illegal code terminates a fresh session without writing
        pulse_start();
        mn = int'($urandom_range(28, 31));
        issue(mn, 1, 2, 3, 4, 26'h55, 1'b0, ref_enc(mn, 1, 2, 3, 4, 26'h55));

        // capacity limit on the 4-word instance
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        in_mnem = 5'd1; in_rs = 5'd7; in_rt = 5'd8; in_rd = 5'd9; in_shamt = 5'd0;
        valid_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i < 4) begin
                chk("cap_we", we_b, 1);
                chk("cap_addr", addr_b, i);
                chk("cap_wdata", wdata_b, ref_enc(1, 7, 8, 9, 0, 26'h0));
            end else begin
                chk("cap_fifth_no_write", we_b, 0);
            end
        end
        valid_b = 1'b0;
        chk("cap_done", done_b, 1);
        chk("cap_count", wc_b, 4);
        chk("cap_ready", ready_b, 0);
        chk("cap_err", err_b, 0);

        // reset the cycle after an accept cancels the pending strobe
        pulse_start();
        in_mnem = 5'd2; in_rs = 5'd3; in_rt = 5'd4; in_rd = 5'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_wdata", imem_wdata, 0);
        chk("mid_rst_count", word_count, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("post_rst_idle_ready", in_ready, 0);
        chk("post_rst_idle_we", imem_we, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential instruction encoder and program loader. Accepts symbolic instruction requests (mnemonic, register fields, immediate/target) over a valid/ready handshake, packs them into 32-bit MIPS words, and writes them to consecutive instruction-memory addresses. It is the encode-side counterpart of the processor's control decoder: every word it emits must decode back to the requested operation. It is used by the boot path and testbenches to load programs before the core is released.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load session at address 0
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_mnem  in  5  mnemonic code
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_imm  in  26  imm16 in [15:0] for I-type; target in [25:0] for J-type
- in_last  in  1  final instruction of the program
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- word_count  out  ADDR_W+1  words written this session
- done  out  1  session completed normally (level)
- err  out  1  illegal mnemonic seen (level)

## Operation
- Mnemonic codes: 0 NOP, 1 ADD, 2 ADDU, 3 SUB, 4 SUBU, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLL, 11 SRL, 12 JR, 13 JALR, 14 ADDI, 15 ADDIU, 16 SLTI, 17 ANDI, 18 ORI, 19 XORI, 20 LW, 21 SW, 22 BEQ, 23 BNE, 24 BLTZ, 25 BGEZ, 26 J, 27 JAL; 28-31 illegal.
- R-type {000000, rs, rt, rd, shamt, funct}; funct ADD 20h, ADDU 21h, SUB 22h, SUBU 23h, AND 24h, OR 25h, XOR 26h, NOR 27h, SLT 2Ah, SLL 00h, SRL 02h, JR 08h, JALR 09h.
- Field forcing: shamt=0 except SLL/SRL; rs=0 for SLL/SRL; JR forces rt, rd, shamt to 0; JALR forces rt, shamt to 0.
- I-type {op, rs, rt, imm[15:0]}; op ADDI 8, ADDIU 9, SLTI 10, ANDI 12, ORI 13, XORI 14, LW 35, SW 43, BEQ 4, BNE 5. in_imm[25:16] ignored.
- REGIMM op 1: rt field forced to 0 (BLTZ) or 1 (BGEZ); in_rt ignored.
- J-type {op, imm[25:0]}; J op 2, JAL op 3. NOP = 32'h0.
- States: IDLE, LOAD, DONE, ERROR. Reset → IDLE.
- IDLE/DONE/ERROR + start → LOAD; pointer, word_count, done, err cleared. start in LOAD ignored.
- LOAD: in_ready=1. Legal accept → write to pointer, pointer+1, word_count+1. Accept with in_last, or accept writing address 2^ADDR_W-1 → DONE. Pointer never wraps.
- Illegal accept → ERROR, no write, err=1; word_count holds.
- in_ready=0 in every state except LOAD.

## Timing
- All outputs registered. Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, word_count 0, done 0, err 0.
- Latency: imem_we/addr/wdata valid the cycle after accept, exactly one cycle per word; throughput one word per cycle.
- done/err rise in the same cycle as the final write strobe (err: cycle after the illegal accept); held until start or reset.
- in_ready drops in the cycle after the terminating accept; no second request is accepted in that cycle.
- Reset mid-session: immediate return to IDLE, any pending write strobe cancelled, memory contents untouched.

## Structure
- Shared package mips_isa_pkg: opcode and funct constants, mnemonic enumeration, REGIMM rt codes; same constants consumed by the control decoder.
- Sub-module instr_field_packer: combinational mnemonic+fields → 32-bit word plus illegal flag; top level holds FSM, pointer, counters, and output registers.

## Test plan
- start; ADD rs=1 rt=2 rd=3 → addr 0, wdata 00221820h; SW rs=29 rt=5 imm=8 → addr 1, AFA50008h; ADDI rt=8 imm=FFFFh in_last → addr 2, 2008FFFFh; done=1, word_count=3.
- SLL rs=9 rt=3 rd=2 shamt=4 → 00031100h (rs forced 0); BGEZ rs=4 imm=3 → 04810003h; BLTZ rs=4 rt=7 imm=3 → 04800003h.
- JAL imm=000010h → 0C000010h; NOP → 00000000h; JR rs=31 rt=5 → 03E00008h.
- Illegal mnem 30 after two legal words → no write, err=1, word_count=2, in_ready=0 until start.
- ADDR_W=2: four back-to-back requests, no in_last → addrs 0-3, done=1 after fourth, fifth in_valid not accepted.
- reset asserted the cycle after an accept → imem_we=0 that cycle, all outputs at reset values, state IDLE.
